// File: rtl/hex_scan_driver.sv
// hex_scan_driver: time-multiplexed multi-digit hexadecimal seven-segment driver.
// Holds a DIGITS-wide hex word (plus decimal points and blank mask) captured by
// load, and scans one digit per SCAN_DIV-cycle slot over shared segment lines.
// Each slot starts with GUARD cycles of all anodes off to avoid ghosting.
// Every output is registered from the current scan state and shadow registers.
module hex_scan_driver #(
  parameter int DIGITS           = 4,
  parameter int SCAN_DIV         = 50000,
  parameter int GUARD            = 1,
  parameter int LZ_BLANK         = 1,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  en,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     anode,
  output logic                  frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic AN_ON  = (ANODE_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic AN_OFF = (ANODE_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Hex nibble to active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0011000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Shadow registers
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   dpsh_q, dpsh_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  // Scan state
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                wrap_q, wrap_d;
  // Output registers
  logic [6:0]          segments_q, segments_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic                frame_tick_q, frame_tick_d;
  // Combinational helpers
  logic                guard_ok_s;
  logic [DIGITS-1:0]   lz_s;

  generate
    if (GUARD == 0) begin : g_no_guard
      assign guard_ok_s = 1'b1;
    end else begin : g_guard
      assign guard_ok_s = (cnt_q >= CNT_W'(GUARD));
    end
  endgenerate

  // Shadow capture: level-sampled load, hold otherwise.
  always_comb begin
    value_d = value_q;
    dpsh_d  = dpsh_q;
    blank_d = blank_q;
    if (load) begin
      value_d = value;
      dpsh_d  = dp_in;
      blank_d = blank_mask;
    end else begin
      value_d = value_q;
      dpsh_d  = dpsh_q;
      blank_d = blank_q;
    end
  end

  // Slot counter and digit index; wrap_d marks the frame boundary transition.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d  = '0;
        wrap_d = 1'b1;
      end else begin
        idx_d  = idx_q + IDX_W'(1);
        wrap_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Leading-zero map: digit d>0 is blanked when it and all higher nibbles are zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_s       = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      upper_zero = upper_zero & (value_q[4*d +: 4] == 4'h0);
      if ((d > 0) && (LZ_BLANK != 0)) begin
        lz_s[d] = upper_zero;
      end else begin
        lz_s[d] = 1'b0;
      end
    end
  end

  // Segment/dp selection for the digit currently being scanned.
  always_comb begin
    segments_d = SEG_OFF;
    dp_d       = 1'b1;
    if (blank_q[idx_q]) begin
      segments_d = SEG_OFF;
      dp_d       = 1'b1;
    end else if (lz_s[idx_q]) begin
      segments_d = SEG_OFF;
      dp_d       = ~dpsh_q[idx_q];
    end else begin
      segments_d = hex_to_seg(value_q[{idx_q, 2'b00} +: 4]);
      dp_d       = ~dpsh_q[idx_q];
    end
  end

  // Anode enables: only the scanned digit, past its guard interval, with en high.
  always_comb begin
    anode_d = {DIGITS{AN_OFF}};
    for (int i = 0; i < DIGITS; i++) begin
      if (en && guard_ok_s && (idx_q == IDX_W'(i))) begin
        anode_d[i] = AN_ON;
      end else begin
        anode_d[i] = AN_OFF;
      end
    end
  end

  // Frame tick lands on the first output cycle of the new digit-0 slot.
  always_comb begin
    frame_tick_d = wrap_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q      <= '0;
      dpsh_q       <= '0;
      blank_q      <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      wrap_q       <= 1'b0;
      segments_q   <= SEG_OFF;
      dp_q         <= 1'b1;
      anode_q      <= {DIGITS{AN_OFF}};
      frame_tick_q <= 1'b0;
    end else begin
      value_q      <= value_d;
      dpsh_q       <= dpsh_d;
      blank_q      <= blank_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wrap_q       <= wrap_d;
      segments_q   <= segments_d;
      dp_q         <= dp_d;
      anode_q      <= anode_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign segments   = segments_q;
  assign dp         = dp_q;
  assign anode      = anode_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Testbench for hex_scan_driver (DIGITS=4, SCAN_DIV=8, GUARD=2, active-low anodes).
// A cycle-level reference model derives every output from the count of
// non-reset edges since the last reset plus a copy of the loaded data.
module tb_hex_scan_driver;

  localparam int DIGITS = 4;
  localparam int SDIV   = 8;
  localparam int GRD    = 2;
  localparam int FRAME  = DIGITS * SDIV;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        en;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  anode;
  logic        frame_tick;

  int checks;
  int failures;

  // Reference model state
  int          n_edges;   // non-reset edges since last reset
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  logic [6:0]  seg_tab [16];

  hex_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SDIV), .GUARD(GRD), .LZ_BLANK(1), .ANODE_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .blank_mask(blank_mask), .en(en), .segments(segments), .dp(dp),
    .anode(anode), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge: predict outputs, step the model, then compare after the edge.
  task automatic cycle();
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_an;
    logic       e_ft;
    int         pos, d, c;
    if (reset) begin
      e_seg = 7'b1111111; e_dp = 1'b1; e_an = 4'b1111; e_ft = 1'b0;
    end else begin
      pos = n_edges % FRAME;
      d   = pos / SDIV;
      c   = pos % SDIV;
      e_ft = (n_edges > 0) && (pos == 0);
      e_an = (en && c >= GRD) ? ~(4'b0001 << d) : 4'b1111;
      if (m_blank[d]) begin
        e_seg = 7'b1111111; e_dp = 1'b1;
      end else begin
        e_dp = ~m_dp[d];
        if (d > 0 && (m_val >> (4 * d)) == 16'h0000) e_seg = 7'b1111111;
        else e_seg = seg_tab[(m_val >> (4 * d)) & 16'h000F];
      end
    end
    @(posedge clk);
    if (reset) begin
      n_edges = 0; m_val = 16'h0000; m_dp = 4'h0; m_blank = 4'h0;
    end else begin
      n_edges++;
      if (load) begin
        m_val = value; m_dp = dp_in; m_blank = blank_mask;
      end
    end
    #1;
    checks++;
    assert (segments === e_seg) else begin
      failures++; $error("FAIL segments t=%0t observed=%b expected=%b", $time, segments, e_seg);
    end
    checks++;
    assert (dp === e_dp) else begin
      failures++; $error("FAIL dp t=%0t observed=%b expected=%b", $time, dp, e_dp);
    end
    checks++;
    assert (anode === e_an) else begin
      failures++; $error("FAIL anode t=%0t observed=%b expected=%b", $time, anode, e_an);
    end
    checks++;
    assert (frame_tick === e_ft) else begin
      failures++; $error("FAIL frame_tick t=%0t observed=%b expected=%b", $time, frame_tick, e_ft);
    end
  endtask

  // Load a word/dp/blank for one cycle, then let the scan run.
  task automatic load_and_run(input logic [15:0] v, input logic [3:0] p,
                              input logic [3:0] b, input int cycles);
    value = v; dp_in = p; blank_mask = b; load = 1'b1;
    cycle();
    load = 1'b0;
    repeat (cycles) cycle();
  endtask

  initial begin
    int first_on;
    int guard_cnt;
    int ticks;
    checks = 0; failures = 0;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    n_edges = 0; m_val = 16'h0000; m_dp = 4'h0; m_blank = 4'h0;
    reset = 1'b1; load = 1'b0; value = 16'h0000; dp_in = 4'h0;
    blank_mask = 4'h0; en = 1'b0;

    // Reset state
    repeat (3) cycle();
    reset = 1'b0; en = 1'b1;

    // Main scan with a full word, several frames
    load_and_run(16'h12AF, 4'h0, 4'h0, 3 * FRAME);
    // Leading-zero blanking cases
    load_and_run(16'h0005, 4'h0, 4'h0, FRAME);
    load_and_run(16'h0000, 4'h0, 4'h0, FRAME);
    // Decimal point on a digit below a non-zero digit
    load_and_run(16'h0400, 4'b0010, 4'h0, FRAME);
    // Forced blank
    load_and_run(16'h8888, 4'h3, 4'b0100, FRAME);

    // en low mid-scan; frame_tick cadence must stay intact
    repeat (5) cycle();
    en = 1'b0;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (frame_tick === 1'b1) ticks++;
    end
    en = 1'b1;
    for (int i = 0; i < 2 * FRAME - 20; i++) begin
      cycle();
      if (frame_tick === 1'b1) ticks++;
    end
    checks++;
    assert (ticks == 2) else begin
      failures++; $error("FAIL frame_tick_count observed=%0d expected=%0d", ticks, 2);
    end

    // Reset mid-slot of digit 2 (bounded search for the slot)
    guard_cnt = 0;
    while ((n_edges % FRAME) != 2 * SDIV + 4 && guard_cnt < 2 * FRAME) begin
      cycle();
      guard_cnt++;
    end
    checks++;
    assert (guard_cnt < 2 * FRAME) else begin
      failures++; $error("FAIL reach_digit2 observed=%0d expected<%0d", guard_cnt, 2 * FRAME);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    first_on = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (first_on == 0 && anode !== 4'b1111) first_on = i;
    end
    checks++;
    assert (first_on == GRD + 1) else begin
      failures++; $error("FAIL first_anode_edge observed=%0d expected=%0d", first_on, GRD + 1);
    end

    // Randomized traffic: loads, held loads, en toggles, rare resets
    for (int i = 0; i < 600; i++) begin
      load       = ($urandom_range(0, 7) == 0);
      value      = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp_in      = 4'($urandom);
      blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 15) == 0) en = ~en;
      reset      = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0; load = 1'b0;
    repeat (FRAME) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
